// File: rtl/am_access_scheduler_pkg.sv
// Shared definitions for the associative-memory access scheduler: AM modes,
// scheduler FSM encoding and the "no class" sentinel returned for untrained queries.
package am_access_scheduler_pkg;

   localparam logic [1:0] MODE_TRAIN   = 2'd0;
   localparam logic [1:0] MODE_PREDICT = 2'd1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RES = 2'd2,
      ST_DELIVER  = 2'd3
   } state_t;

   // All-ones sentinel; users slice the low bits matching their own field width.
   localparam int unsigned          SENTINEL_WIDTH = 32;
   localparam logic [SENTINEL_WIDTH-1:0] NO_CLASS  = '1;

endpackage

// File: rtl/am_access_scheduler_rr.sv
// Two-port round-robin arbiter (train vs query). Grants are combinational; the
// preference pointer moves to the port that was not granted after every grant.
module am_rr_arbiter (
   input  logic CLK_CI,
   input  logic Reset_RBI,
   input  logic Enable_SI,
   input  logic ReqTrain_SI,
   input  logic ReqQuery_SI,
   output logic GrantTrain_SO,
   output logic GrantQuery_SO
);

   logic PreferQuery_SP;

   always_comb begin
      GrantTrain_SO = 1'b0;
      GrantQuery_SO = 1'b0;
      if (Enable_SI) begin
         if (ReqTrain_SI && (!ReqQuery_SI || !PreferQuery_SP)) begin
            GrantTrain_SO = 1'b1;
         end else if (ReqQuery_SI) begin
            GrantQuery_SO = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
         PreferQuery_SP <= 1'b0;
      end else if (GrantTrain_SO) begin
         PreferQuery_SP <= 1'b1;
      end else if (GrantQuery_SO) begin
         PreferQuery_SP <= 1'b0;
      end
   end

endmodule

// File: rtl/am_access_scheduler.sv
// Shares one associative memory between a training stream and a query stream,
// one request in flight at a time; untrained queries are answered locally.
module am_access_scheduler
   import am_access_scheduler_pkg::*;
#(
   parameter int unsigned LABEL_WIDTH    = 8,
   parameter int unsigned HV_DIMENSION   = 8,
   parameter int unsigned DISTANCE_WIDTH = 8,
   parameter int unsigned CLASSES        = 16
) (
   input  logic                      CLK_CI,
   input  logic                      Reset_RBI,
   input  logic                      TrainValid_SI,
   input  logic [LABEL_WIDTH-1:0]    TrainLabel_DI,
   input  logic [HV_DIMENSION-1:0]   TrainHV_DI,
   output logic                      TrainReady_SO,
   input  logic                      QueryValid_SI,
   input  logic [HV_DIMENSION-1:0]   QueryHV_DI,
   output logic                      QueryReady_SO,
   output logic                      ResultValid_SO,
   output logic [LABEL_WIDTH-1:0]    ResultLabel_DO,
   output logic [DISTANCE_WIDTH-1:0] ResultDistance_DO,
   input  logic                      ResultReady_SI,
   output logic                      AmValid_SO,
   output logic [1:0]                AmMode_SO,
   output logic [LABEL_WIDTH-1:0]    AmLabel_DO,
   output logic [HV_DIMENSION-1:0]   AmHV_DO,
   input  logic                      AmReady_SI,
   input  logic                      AmValid_SI,
   input  logic [LABEL_WIDTH-1:0]    AmLabel_DI,
   input  logic [DISTANCE_WIDTH-1:0] AmDistance_DI,
   output logic                      AmReady_SO,
   output logic                      LabelError_SO,
   output logic [CLASSES-1:0]        TrainedMask_DO,
   output logic [1:0]                FsmState_DO
);

   localparam int unsigned IDX_W = (CLASSES > 1) ? $clog2(CLASSES) : 1;
   localparam logic [LABEL_WIDTH:0] CLASS_LIMIT = (LABEL_WIDTH + 1)'(CLASSES);

   state_t State_SP;
   logic   GrantTrain_S;
   logic   GrantQuery_S;
   logic   LabelOutOfRange_S;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // a source holds valid and data stable until then, and ready never waits on a later valid.
   am_rr_arbiter i_arbiter (
      .CLK_CI        (CLK_CI),
      .Reset_RBI     (Reset_RBI),
      .Enable_SI     (State_SP == ST_IDLE),
      .ReqTrain_SI   (TrainValid_SI),
      .ReqQuery_SI   (QueryValid_SI),
      .GrantTrain_SO (GrantTrain_S),
      .GrantQuery_SO (GrantQuery_S)
   );

   assign TrainReady_SO     = GrantTrain_S;
   assign QueryReady_SO     = GrantQuery_S;
   assign AmReady_SO        = (State_SP == ST_WAIT_RES) && AmValid_SI;
   assign LabelOutOfRange_S = ({1'b0, TrainLabel_DI} >= CLASS_LIMIT);
   assign FsmState_DO       = State_SP;

   always_ff @(posedge CLK_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
         State_SP          <= ST_IDLE;
         AmValid_SO        <= 1'b0;
         AmMode_SO         <= MODE_TRAIN;
         AmLabel_DO        <= '0;
         AmHV_DO           <= '0;
         ResultValid_SO    <= 1'b0;
         ResultLabel_DO    <= '0;
         ResultDistance_DO <= '0;
         LabelError_SO     <= 1'b0;
         TrainedMask_DO    <= '0;
      end else begin
         case (State_SP)
            ST_IDLE: begin
               if (GrantTrain_S) begin
                  if (LabelOutOfRange_S) begin
                     LabelError_SO <= 1'b1;
                  end else begin
                     AmMode_SO  <= MODE_TRAIN;
                     AmLabel_DO <= TrainLabel_DI;
                     AmHV_DO    <= TrainHV_DI;
                     AmValid_SO <= 1'b1;
                     State_SP   <= ST_ISSUE;
                  end
               end else if (GrantQuery_S) begin
                  AmMode_SO  <= MODE_PREDICT;
                  AmLabel_DO <= '0;
                  AmHV_DO    <= QueryHV_DI;
                  // Nothing trained yet: the AM has no answer, so reply with the sentinel.
                  if (TrainedMask_DO == '0) begin
                     ResultLabel_DO    <= NO_CLASS[LABEL_WIDTH-1:0];
                     ResultDistance_DO <= NO_CLASS[DISTANCE_WIDTH-1:0];
                     ResultValid_SO    <= 1'b1;
                     State_SP          <= ST_DELIVER;
                  end else begin
                     AmValid_SO <= 1'b1;
                     State_SP   <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (AmReady_SI) begin
                  AmValid_SO <= 1'b0;
                  if (AmMode_SO == MODE_TRAIN) begin
                     TrainedMask_DO[AmLabel_DO[IDX_W-1:0]] <= 1'b1;
                     State_SP <= ST_IDLE;
                  end else begin
                     State_SP <= ST_WAIT_RES;
                  end
               end
            end
            ST_WAIT_RES: begin
               if (AmValid_SI) begin
                  ResultLabel_DO    <= AmLabel_DI;
                  ResultDistance_DO <= AmDistance_DI;
                  ResultValid_SO    <= 1'b1;
                  State_SP          <= ST_DELIVER;
               end
            end
            ST_DELIVER: begin
               if (ResultReady_SI) begin
                  ResultValid_SO <= 1'b0;
                  State_SP       <= ST_IDLE;
               end
            end
            default: State_SP <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_am_access_scheduler.sv
// Bench for am_access_scheduler: directed scenarios plus a randomized phase, with a
// behavioural AM responder and a class-level reference model of training and queries.
module tb_am_access_scheduler;
   import am_access_scheduler_pkg::*;

   logic        CLK_CI;
   logic        Reset_RBI;
   logic        TrainValid_SI;
   logic [7:0]  TrainLabel_DI;
   logic [7:0]  TrainHV_DI;
   logic        TrainReady_SO;
   logic        QueryValid_SI;
   logic [7:0]  QueryHV_DI;
   logic        QueryReady_SO;
   logic        ResultValid_SO;
   logic [7:0]  ResultLabel_DO;
   logic [7:0]  ResultDistance_DO;
   logic        ResultReady_SI;
   logic        AmValid_SO;
   logic [1:0]  AmMode_SO;
   logic [7:0]  AmLabel_DO;
   logic [7:0]  AmHV_DO;
   logic        AmReady_SI;
   logic        AmValid_SI;
   logic [7:0]  AmLabel_DI;
   logic [7:0]  AmDistance_DI;
   logic        AmReady_SO;
   logic        LabelError_SO;
   logic [15:0] TrainedMask_DO;
   logic [1:0]  FsmState_DO;

   am_access_scheduler #(
      .LABEL_WIDTH(8), .HV_DIMENSION(8), .DISTANCE_WIDTH(8), .CLASSES(16)
   ) dut (
      .CLK_CI(CLK_CI), .Reset_RBI(Reset_RBI),
      .TrainValid_SI(TrainValid_SI), .TrainLabel_DI(TrainLabel_DI), .TrainHV_DI(TrainHV_DI),
      .TrainReady_SO(TrainReady_SO),
      .QueryValid_SI(QueryValid_SI), .QueryHV_DI(QueryHV_DI), .QueryReady_SO(QueryReady_SO),
      .ResultValid_SO(ResultValid_SO), .ResultLabel_DO(ResultLabel_DO),
      .ResultDistance_DO(ResultDistance_DO), .ResultReady_SI(ResultReady_SI),
      .AmValid_SO(AmValid_SO), .AmMode_SO(AmMode_SO), .AmLabel_DO(AmLabel_DO), .AmHV_DO(AmHV_DO),
      .AmReady_SI(AmReady_SI), .AmValid_SI(AmValid_SI), .AmLabel_DI(AmLabel_DI),
      .AmDistance_DI(AmDistance_DI), .AmReady_SO(AmReady_SO),
      .LabelError_SO(LabelError_SO), .TrainedMask_DO(TrainedMask_DO), .FsmState_DO(FsmState_DO)
   );

   // ---------------- clock ----------------
   initial begin
      CLK_CI = 1'b0;
      forever #5 CLK_CI = ~CLK_CI;
   end

   // ---------------- reference model and scoreboard ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_mask = '0;
   logic        exp_lerr = 1'b0;
   logic [7:0]  exp_hv [16];
   logic [7:0]  exp_q [$];
   logic [7:0]  exp_dist_q [$];
   logic        exp_am_pend = 1'b0;
   logic [1:0]  exp_am_mode = '0;
   logic [7:0]  exp_am_label = '0;
   logic [7:0]  exp_am_hv = '0;
   logic        train_acc, query_acc;
   logic [7:0]  last_lab, last_dist;
   int          am_valid_cycles = 0;

   // Nearest trained class by Hamming distance, lowest label on ties; sentinel if none.
   function automatic logic [15:0] nearest(input logic [7:0] hv, input logic [15:0] mask,
                                           input logic [7:0] hvs [16]);
      int         best_d = 1000;
      logic [7:0] best_l = 8'hFF;
      logic [7:0] best_dist = 8'hFF;
      for (int c = 0; c < 16; c++) begin
         if (mask[c]) begin
            int d = $countones(hv ^ hvs[c]);
            if (d < best_d) begin
               best_d = d;
               best_l = 8'(c);
            end
         end
      end
      if (best_d != 1000) best_dist = 8'(best_d);
      return {best_l, best_dist};
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fail_timeout(input string tag);
      n_vec++;
      n_err++;
      $error("FAIL %s: observed timeout expected handshake", tag);
   endtask

   // ---------------- behavioural AM ----------------
   logic        am_slow = 1'b0;
   logic [15:0] am_mask = '0;
   logic [7:0]  am_hv [16];
   logic [15:0] am_res;
   logic        am_pend = 1'b0;
   logic        am_presenting = 1'b0;
   int          am_delay = 0;

   initial begin
      AmReady_SI = 1'b0; AmValid_SI = 1'b0; AmLabel_DI = '0; AmDistance_DI = '0;
      forever begin
         @(posedge CLK_CI);
         if (!Reset_RBI) begin
            am_mask = '0; am_pend = 1'b0; am_presenting = 1'b0;
         end else begin
            if (AmValid_SI && AmReady_SO) am_presenting = 1'b0;
            if (AmValid_SO && AmReady_SI) begin
               if (AmMode_SO == MODE_TRAIN) begin
                  am_mask[AmLabel_DO[3:0]] = 1'b1;
                  am_hv[AmLabel_DO[3:0]]   = AmHV_DO;
               end else begin
                  am_res   = nearest(AmHV_DO, am_mask, am_hv);
                  am_pend  = 1'b1;
                  am_delay = am_slow ? 40 : $urandom_range(1, 3);
               end
            end
         end
         @(negedge CLK_CI);
         if (!Reset_RBI) begin
            am_pend = 1'b0; am_presenting = 1'b0;
         end else if (am_pend) begin
            if (am_delay == 0) begin
               am_presenting = 1'b1; am_pend = 1'b0;
               AmLabel_DI = am_res[15:8]; AmDistance_DI = am_res[7:0];
            end else begin
               am_delay--;
            end
         end
         AmValid_SI = am_presenting;
         AmReady_SI = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- driver tasks ----------------
   // One cycle: sample/check at the falling edge, update the model, return #1 after the rising edge.
   task automatic step();
      @(negedge CLK_CI);
      train_acc = TrainReady_SO;
      query_acc = QueryReady_SO;
      chk1("one_ready", TrainReady_SO & QueryReady_SO, 1'b0);
      if (FsmState_DO == ST_IDLE) begin
         chkv("trained_mask", 32'(TrainedMask_DO), 32'(exp_mask));
         chk1("label_error", LabelError_SO, exp_lerr);
      end else begin
         chk1("busy_no_ready", TrainReady_SO | QueryReady_SO, 1'b0);
      end
      if (AmValid_SO) begin
         am_valid_cycles++;
         chk1("am_req_expected", exp_am_pend, 1'b1);
         chkv("am_mode", 32'(AmMode_SO), 32'(exp_am_mode));
         chkv("am_hv", 32'(AmHV_DO), 32'(exp_am_hv));
         if (exp_am_mode == MODE_TRAIN) chkv("am_label", 32'(AmLabel_DO), 32'(exp_am_label));
         if (AmReady_SI) exp_am_pend = 1'b0;
      end
      if (ResultValid_SO && ResultReady_SI) begin
         if (exp_q.size() == 0) begin
            chk1("result_expected", 1'b1, 1'b0);
         end else begin
            last_lab  = exp_q.pop_front();
            last_dist = exp_dist_q.pop_front();
            chkv("result_label", 32'(ResultLabel_DO), 32'(last_lab));
            chkv("result_dist", 32'(ResultDistance_DO), 32'(last_dist));
            last_lab  = ResultLabel_DO;
            last_dist = ResultDistance_DO;
         end
      end
      if (train_acc) begin
         chk1("train_ready_valid", TrainValid_SI, 1'b1);
         if (TrainLabel_DI >= 8'd16) begin
            exp_lerr = 1'b1;
         end else begin
            exp_mask[TrainLabel_DI[3:0]] = 1'b1;
            exp_hv[TrainLabel_DI[3:0]]   = TrainHV_DI;
            exp_am_pend = 1'b1; exp_am_mode = MODE_TRAIN;
            exp_am_label = TrainLabel_DI; exp_am_hv = TrainHV_DI;
         end
      end
      if (query_acc) begin
         logic [15:0] r;
         chk1("query_ready_valid", QueryValid_SI, 1'b1);
         r = nearest(QueryHV_DI, exp_mask, exp_hv);
         exp_q.push_back(r[15:8]);
         exp_dist_q.push_back(r[7:0]);
         if (exp_mask != '0) begin
            exp_am_pend = 1'b1; exp_am_mode = MODE_PREDICT; exp_am_hv = QueryHV_DI;
         end
      end
      @(posedge CLK_CI);
      #1;
   endtask

   task automatic send_train(input logic [7:0] lab, input logic [7:0] hv);
      int n = 0;
      TrainValid_SI = 1'b1; TrainLabel_DI = lab; TrainHV_DI = hv;
      do begin step(); n++; end while (!train_acc && n < 200);
      TrainValid_SI = 1'b0;
      if (!train_acc) fail_timeout("train_accept");
   endtask

   task automatic send_query(input logic [7:0] hv);
      int n = 0;
      QueryValid_SI = 1'b1; QueryHV_DI = hv;
      do begin step(); n++; end while (!query_acc && n < 200);
      QueryValid_SI = 1'b0;
      if (!query_acc) fail_timeout("query_accept");
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || FsmState_DO != ST_IDLE) && n < 400) begin
         step(); n++;
      end
      if (n >= 400) fail_timeout("drain");
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int         n;
      int         av0;
      logic [7:0] hold_lab, hold_dist;
      int         order [$];

      Reset_RBI = 1'b0; TrainValid_SI = 1'b0; TrainLabel_DI = '0; TrainHV_DI = '0;
      QueryValid_SI = 1'b0; QueryHV_DI = '0; ResultReady_SI = 1'b1;
      #12;
      chk1("rst_am_valid", AmValid_SO, 1'b0);
      chk1("rst_result_valid", ResultValid_SO, 1'b0);
      chkv("rst_mask", 32'(TrainedMask_DO), 32'h0);
      @(posedge CLK_CI); #1;
      Reset_RBI = 1'b1;

      // Idle after reset: nothing moves for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         step();
         chkv("idle_state", 32'(FsmState_DO), 32'(ST_IDLE));
         chk1("idle_am_valid", AmValid_SO, 1'b0);
         chk1("idle_am_ready", AmReady_SO, 1'b0);
         chk1("idle_result_valid", ResultValid_SO, 1'b0);
         chk1("idle_train_ready", TrainReady_SO, 1'b0);
         chk1("idle_query_ready", QueryReady_SO, 1'b0);
         chkv("idle_result_label", 32'(ResultLabel_DO), 32'h0);
         chkv("idle_am_hv", 32'(AmHV_DO), 32'h0);
      end

      // Query before any training is answered locally with the sentinel.
      av0 = am_valid_cycles;
      send_query(8'h3C);
      chk1("nt_result_valid", ResultValid_SO, 1'b1);
      chkv("nt_label", 32'(ResultLabel_DO), 32'hFF);
      chkv("nt_dist", 32'(ResultDistance_DO), 32'hFF);
      drain();
      chkv("nt_am_valid_cycles", am_valid_cycles, av0);

      // Train label 3 then query one bit away.
      send_train(8'd3, 8'hA5);
      drain();
      chkv("mask_after_train3", 32'(TrainedMask_DO), 32'h0008);
      send_query(8'hA4);
      drain();
      chkv("q_a4_label", 32'(last_lab), 32'd3);
      chkv("q_a4_dist", 32'(last_dist), 32'd1);

      // Both streams valid continuously: grants alternate starting with train.
      TrainValid_SI = 1'b1; TrainLabel_DI = 8'd5; TrainHV_DI = 8'($urandom);
      QueryValid_SI = 1'b1; QueryHV_DI = 8'($urandom);
      n = 0;
      while (order.size() < 4 && n < 400) begin
         step(); n++;
         if (train_acc) begin order.push_back(0); TrainLabel_DI = 8'd7; TrainHV_DI = 8'($urandom); end
         if (query_acc) begin order.push_back(1); QueryHV_DI = 8'($urandom); end
      end
      TrainValid_SI = 1'b0; QueryValid_SI = 1'b0;
      if (order.size() < 4) fail_timeout("rr_grants");
      drain();
      for (int i = 0; i < order.size(); i++) chkv("rr_order", order[i], i % 2);

      // Out-of-range label: accepted, dropped, sticky error.
      av0 = am_valid_cycles;
      send_train(8'd20, 8'h11);
      chk1("bad_label_error", LabelError_SO, 1'b1);
      chk1("bad_label_am_valid", AmValid_SO, 1'b0);
      chkv("bad_label_state", 32'(FsmState_DO), 32'(ST_IDLE));
      repeat (3) step();
      chkv("bad_label_am_cycles", am_valid_cycles, av0);

      // Result held in DELIVER while the consumer stalls; a waiting train is not granted.
      ResultReady_SI = 1'b0;
      send_query(8'h5A);
      TrainValid_SI = 1'b1; TrainLabel_DI = 8'd9; TrainHV_DI = 8'h5B;
      n = 0;
      while (!ResultValid_SO && n < 100) begin step(); n++; end
      if (!ResultValid_SO) fail_timeout("hold_result");
      hold_lab = ResultLabel_DO; hold_dist = ResultDistance_DO;
      for (int i = 0; i < 5; i++) begin
         step();
         chk1("hold_valid", ResultValid_SO, 1'b1);
         chkv("hold_label", 32'(ResultLabel_DO), 32'(hold_lab));
         chkv("hold_dist", 32'(ResultDistance_DO), 32'(hold_dist));
         chk1("hold_no_grant", train_acc, 1'b0);
      end
      ResultReady_SI = 1'b1;
      n = 0;
      do begin step(); n++; end while (!train_acc && n < 100);
      TrainValid_SI = 1'b0;
      if (!train_acc) fail_timeout("post_hold_train");
      drain();
      chk1("label_error_sticky", LabelError_SO, 1'b1);

      // Asynchronous reset while waiting for the AM result.
      am_slow = 1'b1;
      send_query(8'hF0);
      n = 0;
      while (FsmState_DO != ST_WAIT_RES && n < 50) begin step(); n++; end
      if (FsmState_DO != ST_WAIT_RES) fail_timeout("reach_wait_res");
      #2 Reset_RBI = 1'b0;
      #1;
      chkv("arst_state", 32'(FsmState_DO), 32'(ST_IDLE));
      chk1("arst_am_valid", AmValid_SO, 1'b0);
      chk1("arst_am_ready", AmReady_SO, 1'b0);
      chk1("arst_result_valid", ResultValid_SO, 1'b0);
      chk1("arst_label_error", LabelError_SO, 1'b0);
      chkv("arst_mask", 32'(TrainedMask_DO), 32'h0);
      chkv("arst_am_hv", 32'(AmHV_DO), 32'h0);
      exp_mask = '0; exp_lerr = 1'b0; exp_am_pend = 1'b0;
      exp_q.delete(); exp_dist_q.delete();
      am_slow = 1'b0;
      @(negedge CLK_CI); @(negedge CLK_CI);
      Reset_RBI = 1'b1;

      // Random traffic on both streams with random consumer and AM back-pressure.
      for (int i = 0; i < 1500; i++) begin
         if (!TrainValid_SI && $urandom_range(0, 5) == 0) begin
            TrainValid_SI = 1'b1;
            TrainLabel_DI = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255))
                                                        : 8'($urandom_range(0, 15));
            TrainHV_DI = 8'($urandom);
         end
         if (!QueryValid_SI && $urandom_range(0, 4) == 0) begin
            QueryValid_SI = 1'b1;
            QueryHV_DI = 8'($urandom);
         end
         ResultReady_SI = ($urandom_range(0, 3) != 0);
         step();
         if (train_acc) TrainValid_SI = 1'b0;
         if (query_acc) QueryValid_SI = 1'b0;
      end
      TrainValid_SI = 1'b0; QueryValid_SI = 1'b0; ResultReady_SI = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
